// File: rtl/crc32_stream_if.sv
// Stream and result handshake bundle for crc32_stream.
//   master : the side that drives beats in and takes results (framer/deframer, testbench)
//   slave  : the CRC engine
// Signals: s_valid/s_ready/s_data/s_sof/s_eof/s_nbytes/check_en form the input beat stream;
// crc_valid/crc_ready/crc_out/crc_ok/frame_len form the result handshake;
// err_nosof/err_abort are single-cycle framing-error pulses.
interface crc32_stream_if #(
  parameter int unsigned DATA_BYTES = 1
) ();
  localparam int unsigned NbW = $clog2(DATA_BYTES + 1);

  logic                    s_valid;
  logic                    s_ready;
  logic [8*DATA_BYTES-1:0] s_data;
  logic                    s_sof;
  logic                    s_eof;
  logic [NbW-1:0]          s_nbytes;
  logic                    check_en;
  logic                    crc_valid;
  logic                    crc_ready;
  logic [31:0]             crc_out;
  logic                    crc_ok;
  logic [15:0]             frame_len;
  logic                    err_nosof;
  logic                    err_abort;

  modport master (
    output s_valid, s_data, s_sof, s_eof, s_nbytes, check_en, crc_ready,
    input  s_ready, crc_valid, crc_out, crc_ok, frame_len, err_nosof, err_abort
  );

  modport slave (
    input  s_valid, s_data, s_sof, s_eof, s_nbytes, check_en, crc_ready,
    output s_ready, crc_valid, crc_out, crc_ok, frame_len, err_nosof, err_abort
  );
endinterface

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine, DATA_BYTES bytes folded per beat in a single cycle.
// Generate mode returns the FCS; check mode runs over data+FCS and flags a residue match.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : crc32_stream_if.slave (input beat stream, result handshake, error pulses)
// Byte 0 of a beat is s_data[7:0] and is folded first. Results appear the cycle after the
// EOF beat is accepted and hold until crc_ready; no new beats are taken meanwhile.
module crc32_stream #(
  parameter int unsigned DATA_BYTES = 1,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
  parameter bit          REFIN      = 1'b1,
  parameter bit          REFOUT     = 1'b1,
  parameter logic [31:0] RESIDUE    = 32'h2144DF1C
) (
  input logic           clk,
  input logic           rst,
  crc32_stream_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = w[31-k];
    return r;
  endfunction

  // Normal-form (MSB-first) accumulator; REFIN mirrors each byte before it enters.
  function automatic logic [31:0] fold(input logic [31:0] crc_in,
                                       input logic [8*DATA_BYTES-1:0] data,
                                       input int unsigned n);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc_in;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i < n) begin
        b = data[8*i +: 8];
        if (REFIN) b = rev8(b);
        c = c ^ {b, 24'h0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        check_q, check_d;
  logic        s_ready_q, s_ready_d;
  logic        crc_valid_q, crc_valid_d;
  logic [31:0] crc_out_q, crc_out_d;
  logic        crc_ok_q, crc_ok_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        err_nosof_q, err_nosof_d;
  logic        err_abort_q, err_abort_d;

  logic        accept;
  int unsigned nfold;
  logic [31:0] acc_new;
  logic [16:0] len_sum;
  logic [15:0] len_new;
  logic        chk_new;
  logic [31:0] crc_fin;

  always_comb begin
    accept = bus.s_valid & s_ready_q;
    if (!bus.s_eof) begin
      nfold = DATA_BYTES;
    end else if (32'(bus.s_nbytes) > DATA_BYTES) begin
      nfold = DATA_BYTES;
    end else begin
      nfold = 32'(bus.s_nbytes);
    end
    // SOF restarts both the accumulator and the length count from this beat.
    acc_new = fold(bus.s_sof ? INIT : acc_q, bus.s_data, nfold);
    len_sum = {1'b0, (bus.s_sof ? 16'h0 : frame_len_q)} + 17'(nfold);
    len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    chk_new = bus.s_sof ? bus.check_en : check_q;
    crc_fin = (REFOUT ? rev32(acc_new) : acc_new) ^ XOROUT;

    state_d     = state_q;
    acc_d       = acc_q;
    check_d     = check_q;
    crc_out_d   = crc_out_q;
    crc_ok_d    = crc_ok_q;
    frame_len_d = frame_len_q;
    err_nosof_d = 1'b0;
    err_abort_d = 1'b0;

    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          if (state_q == StIdle && !bus.s_sof) begin
            err_nosof_d = 1'b1;
          end else begin
            err_abort_d = (state_q == StRun) && bus.s_sof;
            acc_d       = acc_new;
            frame_len_d = len_new;
            check_d     = chk_new;
            if (bus.s_eof) begin
              state_d   = StHold;
              crc_out_d = crc_fin;
              crc_ok_d  = chk_new && (crc_fin == RESIDUE);
            end else begin
              state_d = StRun;
            end
          end
        end
      end
      StHold: begin
        if (crc_valid_q && bus.crc_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    s_ready_d   = (state_d != StHold);
    crc_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= INIT;
      check_q     <= 1'b0;
      s_ready_q   <= 1'b1;
      crc_valid_q <= 1'b0;
      crc_out_q   <= 32'h0;
      crc_ok_q    <= 1'b0;
      frame_len_q <= 16'h0;
      err_nosof_q <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      check_q     <= check_d;
      s_ready_q   <= s_ready_d;
      crc_valid_q <= crc_valid_d;
      crc_out_q   <= crc_out_d;
      crc_ok_q    <= crc_ok_d;
      frame_len_q <= frame_len_d;
      err_nosof_q <= err_nosof_d;
      err_abort_q <= err_abort_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.frame_len = frame_len_q;
  assign bus.err_nosof = err_nosof_q;
  assign bus.err_abort = err_abort_q;

endmodule
